mulacc: RTL and testbench
=========================

# mulacc

Multiply-accumulate stage for SimpleCore, directly downstream of the 16-bit combinational multiplier. It registers operands onto the multiplier inputs and captures the 16-bit truncated product one cycle later. It then folds the product into a 16-bit accumulator and presents the result over a valid/ready handshake. The execute stage uses it for MUL, MAC, MSU and accumulator-clear operations without putting the multiplier on a single-cycle critical path.

## Interface
Parameters:
- none; all datapaths are fixed at 16 bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- nReset  input  1  reset; one clock; reset is asynchronous and active-low
- macValidIn  input  1  command valid
- macReadyOut  output  1  command accepted when high with macValidIn
- macOpIn  input  2  00 MUL, 01 MAC, 10 MSU, 11 CLR
- macAIn  input  16  operand A
- macBIn  input  16  operand B
- mulAOut  output  16  registered operand A to the multiplier input A
- mulBOut  output  16  registered operand B to the multiplier input B
- mulResIn  input  16  multiplier product (low 16 bits of mulAOut*mulBOut), combinational
- macValidOut  output  1  result valid
- macReadyIn  input  1  downstream accepts result
- macOut  output  16  accumulator value
- macOvfOut  output  1  sticky overflow/borrow flag

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: macReadyOut=1. On accept, the block latches macAIn and macBIn into mulAOut and mulBOut, latches the op, and moves to EXEC.
- EXEC: macReadyOut=0. The accumulator updates from mulResIn and the FSM moves to DONE.
- Accumulator update rules:
  - MUL: acc <= mulResIn.
  - MAC: acc <= acc + mulResIn.
  - MSU: acc <= acc - mulResIn.
  - CLR: acc <= 0 and macOvfOut <= 0; mulResIn is ignored.
- DONE: macValidOut=1 and macOut=acc.
  - If macReadyIn=1: result handshake completes, and macReadyOut=1 in the same cycle.
  - If macReadyIn=1 and macValidIn=1: a new command is accepted and the FSM goes to EXEC (back-to-back).
  - If macReadyIn=1 and macValidIn=0: the FSM goes to IDLE.
  - If macReadyIn=0: the FSM holds DONE, and macOut, macValidOut and the operand registers stay stable.
- Arithmetic is unsigned modulo 2^16.
- Overflow flag:
  - MAC sets macOvfOut when the 17-bit sum exceeds 16'hFFFF.
  - MSU sets it on borrow (mulResIn > acc).
  - MUL leaves macOvfOut unchanged.
  - The flag is sticky until CLR or reset.
- macAIn, macBIn and macOpIn are ignored when no handshake occurs.

## Timing
- Reset values: FSM=IDLE, mulAOut=0, mulBOut=0, acc/macOut=0, macOvfOut=0, macValidOut=0, macReadyOut=1.
- Accept at edge N: mulAOut/mulBOut are valid after N, acc updates at N+1, and macValidOut is high after N+1. Latency from accept to result valid is 2 cycles.
- Maximum throughput is one op per 2 cycles (back-to-back acceptance in DONE).
- mulResIn is sampled only in EXEC. The full multiplier path must settle within one cycle.
- If nReset is asserted in any state, all outputs return to reset values immediately. An in-flight op is discarded and no result is produced.
- macReadyOut is a combinational function of state and macReadyIn only; it never depends on macValidIn.

## Configuration
- MULACC_SAT_EN defined: MAC saturates acc to 16'hFFFF on overflow, and MSU clamps acc to 16'h0000 on borrow. macOvfOut is still set.
- MULACC_SAT_EN undefined: MAC and MSU wrap modulo 2^16, and macOvfOut is set.

## Test plan
- Reset then MUL A=16'h0003 B=16'h0005 -> macValidOut high 2 cycles after accept, macOut=16'h000F, macOvfOut=0.
- MUL 0x0100*0x0010, then MAC 0xFFFF*0x0001 -> without MULACC_SAT_EN macOut=16'h0FFF, macOvfOut=1; with MULACC_SAT_EN macOut=16'hFFFF, macOvfOut=1.
- After macOut=16'h0002, MSU 0x0003*0x0001 -> macOut=16'hFFFF without SAT (16'h0000 with SAT), macOvfOut=1. A following CLR -> macOut=0, macOvfOut=0.
- Hold macReadyIn=0 for 5 cycles in DONE -> macOut, macValidOut=1 and macReadyOut=0 stay stable, with no new accept. Raise macReadyIn with macValidIn=1 (MAC 2*2) -> same-cycle accept, next result = previous+4.
- Back-to-back MAC 1*1 ten times with macReadyIn=1 -> results 1..10, one every 2 cycles.
- Assert nReset during EXEC of MUL 0xFFFF*0xFFFF -> all outputs at reset values next, no macValidOut pulse. After release, the first MAC 1*1 gives macOut=1.

Source files
------------

// File: rtl/mulacc_if.sv
// Command, result and multiplier-side signals of the mulacc stage.
interface mulacc_if;
  logic        macValidIn;
  logic        macReadyOut;
  logic [1:0]  macOpIn;
  logic [15:0] macAIn;
  logic [15:0] macBIn;
  logic [15:0] mulAOut;
  logic [15:0] mulBOut;
  logic [15:0] mulResIn;
  logic        macValidOut;
  logic        macReadyIn;
  logic [15:0] macOut;
  logic        macOvfOut;

  modport slave (
    input  macValidIn, macOpIn, macAIn, macBIn, mulResIn, macReadyIn,
    output macReadyOut, mulAOut, mulBOut, macValidOut, macOut, macOvfOut
  );

  modport master (
    output macValidIn, macOpIn, macAIn, macBIn, mulResIn, macReadyIn,
    input  macReadyOut, mulAOut, mulBOut, macValidOut, macOut, macOvfOut
  );
endinterface

// File: rtl/mulacc.sv
// Multiply-accumulate stage: registers operands for the external multiplier, folds the
// product into a 16-bit accumulator. Define MULACC_SAT_EN for saturating MAC/MSU.
module mulacc (
  input  logic     clk,
  input  logic     nReset,
  mulacc_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MAC = 2'b01;
  localparam logic [1:0] OP_MSU = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  op_q, op_d;
  logic        ovf_q, ovf_d;

  logic        ready_s;
  logic        accept_s;
  logic [16:0] sum_s;
  logic [15:0] diff_s;
  logic        borrow_s;

  // Ready depends only on state and downstream ready, never on the incoming valid.
  assign ready_s  = (state_q == IDLE) || ((state_q == DONE) && bus.macReadyIn);
  assign accept_s = ready_s && bus.macValidIn;

  assign sum_s    = {1'b0, acc_q} + {1'b0, bus.mulResIn};
  assign diff_s   = acc_q - bus.mulResIn;
  assign borrow_s = (bus.mulResIn > acc_q);

  // State, operand and accumulator registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      acc_q   <= 16'h0000;
      op_q    <= OP_MUL;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, operand capture and accumulator update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    if (accept_s) begin
      a_d  = bus.macAIn;
      b_d  = bus.macBIn;
      op_d = bus.macOpIn;
    end else begin
      a_d  = a_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d = DONE;
        case (op_q)
          OP_MUL: begin
            acc_d = bus.mulResIn;
          end
          OP_MAC: begin
            if (sum_s[16]) begin
              ovf_d = 1'b1;
`ifdef MULACC_SAT_EN
              acc_d = 16'hFFFF;
`else
              acc_d = sum_s[15:0];
`endif
            end else begin
              acc_d = sum_s[15:0];
            end
          end
          OP_MSU: begin
            if (borrow_s) begin
              ovf_d = 1'b1;
`ifdef MULACC_SAT_EN
              acc_d = 16'h0000;
`else
              acc_d = diff_s;
`endif
            end else begin
              acc_d = diff_s;
            end
          end
          OP_CLR: begin
            acc_d = 16'h0000;
            ovf_d = 1'b0;
          end
          default: begin
            acc_d = acc_q;
          end
        endcase
      end
      DONE: begin
        if (bus.macReadyIn) begin
          if (bus.macValidIn) begin
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.macReadyOut = ready_s;
  assign bus.mulAOut     = a_q;
  assign bus.mulBOut     = b_q;
  assign bus.macValidOut = (state_q == DONE);
  assign bus.macOut      = acc_q;
  assign bus.macOvfOut   = ovf_q;

endmodule

// File: tb/tb_mulacc.sv
// Randomised and directed bench for mulacc against an arithmetic reference model.
module tb_mulacc;

  logic clk;
  logic nReset;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] acc_m;
  logic        ovf_m;

  mulacc_if bus ();

  mulacc u_dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  // Stand-in for the combinational multiplier, truncated to 16 bits.
  assign bus.mulResIn = bus.mulAOut * bus.mulBOut;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned arithmetic on wide integers, then clamp or wrap.
  task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    longint p, s;
    p = (longint'(a) * longint'(b)) % 65536;
    case (op)
      2'd0: acc_m = p[15:0];
      2'd1: begin
        s = longint'(acc_m) + p;
        if (s > 65535) begin
          ovf_m = 1'b1;
`ifdef MULACC_SAT_EN
          s = 65535;
`endif
        end
        acc_m = s[15:0];
      end
      2'd2: begin
        s = longint'(acc_m) - p;
        if (s < 0) begin
          ovf_m = 1'b1;
`ifdef MULACC_SAT_EN
          s = 0;
`else
          s = s + 65536;
`endif
        end
        acc_m = s[15:0];
      end
      default: begin
        acc_m = 16'h0000;
        ovf_m = 1'b0;
      end
    endcase
  endtask

  // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge where the result is valid.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.macValidIn = 1'b1;
    bus.macOpIn    = op;
    bus.macAIn     = a;
    bus.macBIn     = b;
    #1;
    check("ready_at_issue", {31'd0, bus.macReadyOut}, 32'd1);
    @(posedge clk);
    #1;
    bus.macValidIn = 1'b0;
    bus.macOpIn    = 2'($urandom_range(0, 3));
    bus.macAIn     = 16'($urandom);
    bus.macBIn     = 16'($urandom);
    model(op, a, b);
    @(negedge clk);
    check("exec_valid", {31'd0, bus.macValidOut}, 32'd0);
    check("exec_ready", {31'd0, bus.macReadyOut}, 32'd0);
    check("mulA", {16'd0, bus.mulAOut}, {16'd0, a});
    check("mulB", {16'd0, bus.mulBOut}, {16'd0, b});
    @(negedge clk);
    check("done_valid", {31'd0, bus.macValidOut}, 32'd1);
    check("macOut", {16'd0, bus.macOut}, {16'd0, acc_m});
    check("macOvf", {31'd0, bus.macOvfOut}, {31'd0, ovf_m});
  endtask

  initial begin
    logic [15:0] held_a;
    logic [15:0] ra, rb;
    nReset         = 1'b0;
    bus.macValidIn = 1'b0;
    bus.macOpIn    = 2'd0;
    bus.macAIn     = 16'h0000;
    bus.macBIn     = 16'h0000;
    bus.macReadyIn = 1'b1;
    acc_m          = 16'h0000;
    ovf_m          = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.macReadyOut}, 32'd1);
    check("rst_valid", {31'd0, bus.macValidOut}, 32'd0);
    check("rst_out", {16'd0, bus.macOut}, 32'd0);
    check("rst_ovf", {31'd0, bus.macOvfOut}, 32'd0);
    check("rst_mulA", {16'd0, bus.mulAOut}, 32'd0);
    nReset = 1'b1;
    @(negedge clk);

    run_op(2'd0, 16'h0003, 16'h0005);
    check("mul3x5", {16'd0, bus.macOut}, 32'h000F);

    run_op(2'd0, 16'h0100, 16'h0010);
    run_op(2'd1, 16'hFFFF, 16'h0001);
`ifdef MULACC_SAT_EN
    check("mac_sat", {16'd0, bus.macOut}, 32'hFFFF);
`else
    check("mac_wrap", {16'd0, bus.macOut}, 32'h0FFF);
`endif
    check("mac_ovf", {31'd0, bus.macOvfOut}, 32'd1);

    run_op(2'd0, 16'h0001, 16'h0002);
    run_op(2'd2, 16'h0003, 16'h0001);
`ifdef MULACC_SAT_EN
    check("msu_clamp", {16'd0, bus.macOut}, 32'h0000);
`else
    check("msu_wrap", {16'd0, bus.macOut}, 32'hFFFF);
`endif
    check("msu_ovf", {31'd0, bus.macOvfOut}, 32'd1);
    run_op(2'd3, 16'h1234, 16'h5678);
    check("clr_ovf", {31'd0, bus.macOvfOut}, 32'd0);

    // Downstream stall: results and operands must hold and nothing new is accepted.
    held_a         = bus.mulAOut;
    bus.macReadyIn = 1'b0;
    bus.macValidIn = 1'b1;
    bus.macOpIn    = 2'd3;
    bus.macAIn     = 16'hDEAD;
    bus.macBIn     = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_ready", {31'd0, bus.macReadyOut}, 32'd0);
      check("stall_valid", {31'd0, bus.macValidOut}, 32'd1);
      check("stall_out", {16'd0, bus.macOut}, {16'd0, acc_m});
      check("stall_mulA", {16'd0, bus.mulAOut}, {16'd0, held_a});
      @(negedge clk);
    end
    bus.macReadyIn = 1'b1;
    run_op(2'd1, 16'h0002, 16'h0002);
    check("stall_plus4", {16'd0, bus.macOut}, 32'h0004);

    run_op(2'd3, 16'h0000, 16'h0000);
    for (int i = 1; i <= 10; i++) begin
      run_op(2'd1, 16'h0001, 16'h0001);
      check("b2b_count", {16'd0, bus.macOut}, i);
    end

    // Reset while the MUL is in EXEC: no result, everything back to reset values.
    bus.macValidIn = 1'b1;
    bus.macOpIn    = 2'd0;
    bus.macAIn     = 16'hFFFF;
    bus.macBIn     = 16'hFFFF;
    @(posedge clk);
    #1;
    bus.macValidIn = 1'b0;
    @(negedge clk);
    nReset = 1'b0;
    #1;
    check("arst_ready", {31'd0, bus.macReadyOut}, 32'd1);
    check("arst_valid", {31'd0, bus.macValidOut}, 32'd0);
    check("arst_out", {16'd0, bus.macOut}, 32'd0);
    check("arst_ovf", {31'd0, bus.macOvfOut}, 32'd0);
    check("arst_mulA", {16'd0, bus.mulAOut}, 32'd0);
    check("arst_mulB", {16'd0, bus.mulBOut}, 32'd0);
    @(negedge clk);
    nReset = 1'b1;
    acc_m  = 16'h0000;
    ovf_m  = 1'b0;
    @(negedge clk);
    check("arst_nopulse", {31'd0, bus.macValidOut}, 32'd0);
    run_op(2'd1, 16'h0001, 16'h0001);
    check("arst_first_mac", {16'd0, bus.macOut}, 32'd1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end else begin
        ra = 16'($urandom_range(0, 300));
        rb = 16'($urandom_range(0, 300));
      end
      run_op(2'($urandom_range(0, 3)), ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
